// File: rtl/key_scan_if.sv
// key_scan_if: raw button levels and repeat enable in, debounced key events out.
interface key_scan_if #(
   parameter int N     = 4,
   parameter int IDX_W = 2
);
   logic [N-1:0]     button;
   logic             rpt_en;
   logic             key_valid;
   logic             key_repeat;
   logic [IDX_W-1:0] key_idx;
   logic             key_release;
   logic             busy;
   modport master (output button, rpt_en, input key_valid, key_repeat, key_idx, key_release, busy);
   modport slave (input button, rpt_en, output key_valid, key_repeat, key_idx, key_release, busy);
endinterface

// File: rtl/key_scan_scheduler.sv
// key_scan_scheduler: shares one debounce/repeat counter among N buttons,
// granting them round-robin and emitting one-cycle press/repeat/release events.
module key_scan_scheduler #(
   parameter int N          = 4,
   parameter int IDX_W      = 2,
   parameter int CNT_W      = 24,
   parameter int DEB_CYCLES = 61440,
   parameter int RPT_DELAY  = 5000000,
   parameter int RPT_PERIOD = 1000000
) (
   input logic        clk,
   input logic        rstn,
   key_scan_if.slave  ks
);
   typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;
   localparam logic [CNT_W-1:0] DEB_M1 = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_M1 = CNT_W'(RPT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_M1 = CNT_W'(RPT_PERIOD - 1);
   state_t           state_q, state_d;
   logic [N-1:0]     s1_q, btn_q;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [IDX_W-1:0] idx_q, idx_d, last_grant_q, last_grant_d, grant;
   logic             rpt_phase_q, rpt_phase_d;
   logic             valid_q, valid_d, repeat_q, repeat_d, release_q, release_d;
   logic             found, hit;

   function automatic logic [IDX_W-1:0] rr(input logic [IDX_W-1:0] lg, input int i);
      return IDX_W'((int'(lg) + i) % N);
   endfunction

   assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
   assign hit = btn_q[idx_q];
   assign ks.key_valid = valid_q;
   assign ks.key_repeat = repeat_q;
   assign ks.key_release = release_q;
   assign ks.key_idx = idx_q;
   assign ks.busy = state_q != IDLE;

   // First pressed button strictly after the last accepted one, wrapping.
   always_comb begin
      grant = last_grant_q;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         if (!found && btn_q[rr(last_grant_q, i)]) begin
            grant = rr(last_grant_q, i);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      idx_d = idx_q;
      last_grant_d = last_grant_q;
      rpt_phase_d = rpt_phase_q;
      valid_d = 1'b0;
      repeat_d = 1'b0;
      release_d = 1'b0;
      case (state_q)
         IDLE: if (|btn_q) begin
            idx_d = grant;
            cnt_d = '0;
            state_d = DEB_PRESS;
         end
         DEB_PRESS: if (!hit) begin
            cnt_d = '0;
            state_d = IDLE;
         end else if (cnt_q == DEB_M1) begin
            valid_d = 1'b1;
            last_grant_d = idx_q;
            cnt_d = '0;
            rpt_phase_d = 1'b0;
            state_d = HELD;
         end else cnt_d = cnt_inc;
         HELD: if (!hit) begin
            cnt_d = '0;
            state_d = DEB_REL;
         end else if (!ks.rpt_en) cnt_d = '0;
         else if (cnt_q == (rpt_phase_q ? PER_M1 : DLY_M1)) begin
            valid_d = 1'b1;
            repeat_d = 1'b1;
            cnt_d = '0;
            rpt_phase_d = 1'b1;
         end else cnt_d = cnt_inc;
         DEB_REL: if (hit) begin
            cnt_d = '0;
            rpt_phase_d = 1'b0;
            state_d = HELD;
         end else if (cnt_q == DEB_M1) begin
            release_d = 1'b1;
            cnt_d = '0;
            state_d = IDLE;
         end else cnt_d = cnt_inc;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q <= '0;
         btn_q <= '0;
         state_q <= IDLE;
         cnt_q <= '0;
         idx_q <= '0;
         last_grant_q <= IDX_W'(N - 1);
         rpt_phase_q <= 1'b0;
         valid_q <= 1'b0;
         repeat_q <= 1'b0;
         release_q <= 1'b0;
      end else begin
         s1_q <= ks.button;
         btn_q <= s1_q;
         state_q <= state_d;
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         last_grant_q <= last_grant_d;
         rpt_phase_q <= rpt_phase_d;
         valid_q <= valid_d;
         repeat_q <= repeat_d;
         release_q <= release_d;
      end
   end
endmodule
